// File: rtl/pipeline_ctrl.sv
// Pipeline control for the 5-stage core: turns hazard-unit stall/flush requests and busy
// signals into register load enables and per-stage valid bits. Counters under PIPELINE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall_if,
    input  logic                 stall_id,
    input  logic                 flush_id,
    input  logic                 flush_ex,
    input  logic                 flush_mem,
    input  logic                 if_valid,
    input  logic                 ex_busy,
    input  logic                 mem_busy,
    input  logic                 perf_clear,
    output logic                 pc_en,
    output logic                 en_if_id,
    output logic                 en_id_ex,
    output logic                 en_ex_mem,
    output logic                 valid_id,
    output logic                 valid_ex,
    output logic                 valid_mem,
    output logic                 valid_wb,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    logic hold_mem;
    logic hold_ex;
    logic hold_id;
    logic hold_if;
    logic flush_any;

    // A busy later stage freezes every stage in front of it.
    always_comb begin
        hold_mem  = mem_busy;
        hold_ex   = hold_mem | ex_busy;
        hold_id   = hold_ex | stall_id;
        hold_if   = hold_id | stall_if;
        flush_any = flush_id | flush_ex | flush_mem;
    end

    // Enable semantics: an enable high means that pipeline register loads its data on the
    // next rising edge; the matching valid bit says whether that data is a real instruction.
    assign pc_en     = !reset && !hold_if && (if_valid || flush_id);
    assign en_if_id  = !reset && !hold_id;
    assign en_id_ex  = !reset && !hold_ex;
    assign en_ex_mem = !reset && !hold_mem;

    // Flush wins over hold, so a frozen stage can still be turned into a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_id  <= 1'b0;
            valid_ex  <= 1'b0;
            valid_mem <= 1'b0;
            valid_wb  <= 1'b0;
        end else begin
            if (flush_id)
                valid_id <= 1'b0;
            else if (!hold_id)
                valid_id <= if_valid & ~stall_if;

            if (flush_ex)
                valid_ex <= 1'b0;
            else if (!hold_ex)
                valid_ex <= valid_id & ~stall_id;

            if (flush_mem)
                valid_mem <= 1'b0;
            else if (!hold_mem)
                valid_mem <= valid_ex & ~ex_busy;

            valid_wb <= valid_mem & ~mem_busy;
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    // Clear takes priority over counting, and the clearing cycle itself is not counted.
    always_ff @(posedge clock) begin
        if (reset || perf_clear) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (valid_wb)
                instret_cnt <= instret_cnt + CNT_WIDTH'(1);
            if (valid_id && hold_id)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (flush_any)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = perf_clear | flush_any;

    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
`endif

endmodule
